// File: rtl/clint_axil_slave.sv
// clint_axil_slave
//   AXI4-Lite slave front end for the CLINT. Decodes 32-bit bus accesses
//   against the CLINT address map. Writes become single-cycle write-enable
//   strobes plus reg_wdata toward clint_core. Reads return the values that
//   clint_core drives on mtime/mtimecmp/msip.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*       AXI4-Lite write address / data / response channels
//   s_ar*/s_r*            AXI4-Lite read address / data channels
//   mtime_l_wen, mtime_h_wen          strobes for mtime[31:0] / mtime[63:32]
//   mtimecmp_l_wen, mtimecmp_h_wen    per-hart strobes for mtimecmp halves
//   msip_wen                          per-hart strobe for msip
//   reg_wdata             data accompanying the strobes
//   mtime, mtimecmp, msip current register values from clint_core
//
// Handshake rule (all channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge; ready never depends combinationally on valid.

module clint_axil_slave #(
    parameter int HART_NUM   = 1,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [ADDR_WIDTH-1:0]    s_awaddr,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    output logic [1:0]               s_bresp,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    input  logic [ADDR_WIDTH-1:0]    s_araddr,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     mtime_l_wen,
    output logic                     mtime_h_wen,
    output logic [HART_NUM-1:0]      mtimecmp_l_wen,
    output logic [HART_NUM-1:0]      mtimecmp_h_wen,
    output logic [HART_NUM-1:0]      msip_wen,
    output logic [31:0]              reg_wdata,
    input  logic [63:0]              mtime,
    input  logic [64*HART_NUM-1:0]   mtimecmp,
    input  logic [HART_NUM-1:0]      msip
);

    localparam int HIDX_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        T_NONE,
        T_MSIP,
        T_CMP_L,
        T_CMP_H,
        T_MTIME_L,
        T_MTIME_H
    } tgt_e;

    typedef struct packed {
        tgt_e              tgt;
        logic [HIDX_W-1:0] hart;
    } dec_t;

    // Word-address decode of addr[15:2]; byte offset bits are ignored.
    function automatic dec_t decode(input logic [13:0] word_addr);
        logic [31:0] word;
        dec_t        d;
        word   = {18'd0, word_addr};
        d.tgt  = T_NONE;
        d.hart = '0;
        if (word < 32'(HART_NUM)) begin
            d.tgt  = T_MSIP;
            d.hart = HIDX_W'(word);
        end else if ((word >= 32'h1000) && (word < (32'h1000 + 32'(2 * HART_NUM)))) begin
            d.tgt  = word[0] ? T_CMP_H : T_CMP_L;
            d.hart = HIDX_W'((word - 32'h1000) >> 1);
        end else if (word == 32'h2FFE) begin
            d.tgt = T_MTIME_L;
        end else if (word == 32'h2FFF) begin
            d.tgt = T_MTIME_H;
        end
        return d;
    endfunction

    // Readies stay low until the first clock after reset release.
    logic        rdy_en;
    logic        aw_held;
    logic        w_held;
    logic [13:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    dec_t        wr_dec;
    dec_t        rd_dec;
    logic [1:0]  wr_resp;
    logic [31:0] rd_data_c;
    logic [1:0]  rd_resp_c;

    // Address bits outside [15:2] do not take part in decoding.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr, s_araddr};

    assign s_awready = rdy_en && !aw_held && !s_bvalid;
    assign s_wready  = rdy_en && !w_held  && !s_bvalid;
    assign s_arready = rdy_en && !s_rvalid;

    assign aw_hs  = s_awvalid && s_awready;
    assign w_hs   = s_wvalid  && s_wready;
    assign ar_hs  = s_arvalid && s_arready;
    assign commit = aw_held && w_held;

    assign wr_dec = decode(awaddr_q);
    assign rd_dec = decode(s_araddr[15:2]);

    always_comb begin
        wr_resp = RESP_OKAY;
        case (wr_dec.tgt)
            T_NONE:  wr_resp = RESP_DECERR;
            T_MSIP:  wr_resp = wstrb_q[0] ? RESP_OKAY : RESP_SLVERR;
            default: wr_resp = (wstrb_q == 4'hF) ? RESP_OKAY : RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_data_c = 32'd0;
        rd_resp_c = RESP_OKAY;
        case (rd_dec.tgt)
            T_MSIP:    rd_data_c = {31'd0, msip[rd_dec.hart]};
            T_CMP_L:   rd_data_c = mtimecmp[64 * int'(rd_dec.hart) +: 32];
            T_CMP_H:   rd_data_c = mtimecmp[64 * int'(rd_dec.hart) + 32 +: 32];
            T_MTIME_L: rd_data_c = mtime[31:0];
            T_MTIME_H: rd_data_c = mtime[63:32];
            default:   rd_resp_c = RESP_DECERR;
        endcase
    end

    // Write channel: latch AW and W independently; commit on the clock after
    // both are held, producing the strobe and the response together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en         <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            s_bvalid       <= 1'b0;
            s_bresp        <= RESP_OKAY;
            reg_wdata      <= '0;
            mtime_l_wen    <= 1'b0;
            mtime_h_wen    <= 1'b0;
            mtimecmp_l_wen <= '0;
            mtimecmp_h_wen <= '0;
            msip_wen       <= '0;
        end else begin
            rdy_en         <= 1'b1;
            mtime_l_wen    <= 1'b0;
            mtime_h_wen    <= 1'b0;
            mtimecmp_l_wen <= '0;
            mtimecmp_h_wen <= '0;
            msip_wen       <= '0;

            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_awaddr[15:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            // Held flags can only be set while bvalid is low, so commit and
            // the B handshake never coincide.
            if (commit) begin
                aw_held   <= 1'b0;
                w_held    <= 1'b0;
                s_bvalid  <= 1'b1;
                s_bresp   <= wr_resp;
                reg_wdata <= wdata_q;
                if (wr_resp == RESP_OKAY) begin
                    case (wr_dec.tgt)
                        T_MSIP:    msip_wen[wr_dec.hart]       <= 1'b1;
                        T_CMP_L:   mtimecmp_l_wen[wr_dec.hart] <= 1'b1;
                        T_CMP_H:   mtimecmp_h_wen[wr_dec.hart] <= 1'b1;
                        T_MTIME_L: mtime_l_wen                 <= 1'b1;
                        T_MTIME_H: mtime_h_wen                 <= 1'b1;
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Read channel: data is captured from clint_core at the AR handshake and
    // held until the master takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_data_c;
                s_rresp  <= rd_resp_c;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

endmodule
